// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer driving the Hack PC load/inc/reset controls.
// Optional fetch watchdog enabled by defining PC_SEQ_TIMEOUT_EN.
module pc_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        halt_req,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [15:0] instr,
    output logic        exec_start,
    input  logic        exec_done,
    input  logic        zr,
    input  logic        ng,
    output logic [15:0] ir,
    output logic        pc_load,
    output logic        pc_inc,
    output logic        pc_reset,
    output logic        busy,
    output logic        err,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        FETCH  = 3'd2,
        EXEC   = 3'd3,
        WAIT   = 3'd4,
        UPDATE = 3'd5,
        HALT   = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] ir_q;
    logic        take_q;
    logic        take_nx;
    logic        halt_pend;
    logic        tmo;

    // A-instructions never jump; C-instructions test jump bits against flags.
    always_comb begin
        take_nx = ir_q[15] & ((ir_q[2] & ng) | (ir_q[1] & zr) | (ir_q[0] & ~ng & ~zr));
    end

`ifdef PC_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tcnt;
    logic          err_q;

    assign tmo = (state == FETCH) && !imem_ack && (tcnt == CW'(TIMEOUT - 1));

    // Counter sits at zero outside FETCH, so every FETCH entry starts fresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state != FETCH) begin
                tcnt <= '0;
            end else if (!imem_ack) begin
                tcnt <= tcnt + 1'b1;
            end
            if (tmo) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CLR;
            CLR:     state_nx = FETCH;
            FETCH: begin
                if (imem_ack) state_nx = EXEC;
                else if (tmo) state_nx = HALT;
            end
            EXEC:    state_nx = WAIT;
            WAIT:    if (exec_done) state_nx = UPDATE;
            UPDATE:  state_nx = halt_pend ? HALT : FETCH;
            HALT:    if (start) state_nx = FETCH;
            default: state_nx = IDLE;
        endcase
    end

    // A halt raised together with start in IDLE is kept for after the first instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q      <= 16'h0000;
            take_q    <= 1'b0;
            halt_pend <= 1'b0;
        end else begin
            if (state == FETCH && imem_ack) begin
                ir_q <= instr;
            end
            if (state == WAIT && exec_done) begin
                take_q <= take_nx;
            end
            if (state_nx == HALT && state != HALT) begin
                halt_pend <= 1'b0;
            end else if (halt_req && (state != IDLE || start)) begin
                halt_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        imem_req   = 1'b0;
        exec_start = 1'b0;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_reset   = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE:    busy = 1'b0;
            CLR:     pc_reset = 1'b1;
            FETCH:   imem_req = 1'b1;
            EXEC:    exec_start = 1'b1;
            WAIT:    busy = 1'b1;
            UPDATE: begin
                pc_load = take_q;
                pc_inc  = ~take_q;
            end
            HALT:    busy = 1'b0;
            default: busy = 1'b0;
        endcase
    end

    assign ir        = ir_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequential/jump instructions,
// wait states, halt/resume and fetch watchdog behaviour.
module tb_pc_sequencer;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLR    = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_UPDATE = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        halt_req;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] instr;
    logic        exec_start;
    logic        exec_done;
    logic        zr;
    logic        ng;
    logic [15:0] ir;
    logic        pc_load;
    logic        pc_inc;
    logic        pc_reset;
    logic        busy;
    logic        err;
    logic [2:0]  state_dbg;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    pc_sequencer #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
        .exec_start(exec_start), .exec_done(exec_done), .zr(zr), .ng(ng),
        .ir(ir), .pc_load(pc_load), .pc_inc(pc_inc), .pc_reset(pc_reset),
        .busy(busy), .err(err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {imem_req, exec_start, pc_load, pc_inc, pc_reset, busy, err};
    endfunction

    // Runs one instruction starting in FETCH and ends sampling its UPDATE cycle.
    task automatic run_instr(input string tag, input logic [15:0] w, input int ack_dly,
                             input int done_dly, input logic z, input logic n,
                             input logic exp_take, input logic halt_in_wait);
        int   fc, wc, cyc, req_n, xs_n, pcp_n;
        logic fin;
        fc = 0; wc = 0; cyc = 0; req_n = 0; xs_n = 0; pcp_n = 0; fin = 1'b0;
        check({tag, "_entry"}, state_dbg, S_FETCH);
        instr = w;
        while (!fin && cyc < 40) begin
            cyc++;
            req_n += int'(imem_req);
            xs_n  += int'(exec_start);
            pcp_n += int'(pc_load) + int'(pc_inc);
            imem_ack = 1'b0; exec_done = 1'b0; halt_req = 1'b0;
            zr = ~z; ng = ~n;
            case (state_dbg)
                S_FETCH: begin
                    fc++;
                    imem_ack = (fc == ack_dly + 1);
                end
                S_EXEC: check({tag, "_ir"}, ir, w);
                S_WAIT: begin
                    wc++;
                    if (halt_in_wait && wc == 1) halt_req = 1'b1;
                    if (wc == done_dly + 1) begin
                        exec_done = 1'b1;
                        zr = z; ng = n;
                    end
                end
                S_UPDATE: begin
                    check({tag, "_load"}, pc_load, exp_take);
                    check({tag, "_inc"}, pc_inc, !exp_take);
                    fin = 1'b1;
                end
                default: ;
            endcase
            if (!fin) tick;
        end
        imem_ack = 1'b0; exec_done = 1'b0; halt_req = 1'b0;
        check({tag, "_reached_update"}, fin, 1);
        check({tag, "_req_cycles"}, req_n, ack_dly + 1);
        check({tag, "_exec_pulses"}, xs_n, 1);
        check({tag, "_pc_pulses"}, pcp_n, 1);
        check({tag, "_period"}, cyc, 4 + ack_dly + done_dly);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; halt_req = 1'b0; imem_ack = 1'b0;
        instr = 16'h0000; exec_done = 1'b0; zr = 1'b0; ng = 1'b0;
        repeat (2) tick;
        check("reset_outs", outs(), 7'd0);
        check("reset_ir", ir, 16'h0000);
        check("reset_state", state_dbg, S_IDLE);

        reset = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        check("clr_state", state_dbg, S_CLR);
        check("clr_pc_reset", pc_reset, 1);
        check("clr_busy", busy, 1);
        tick;
        check("fetch_state", state_dbg, S_FETCH);
        check("fetch_req", imem_req, 1);

        // Asynchronous reset in the middle of a FETCH cycle.
        #2 reset = 1'b0;
        #1;
        check("async_reset_outs", outs(), 7'd0);
        check("async_reset_state", state_dbg, S_IDLE);
        tick;
        reset = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        check("clr2_pc_reset", pc_reset, 1);
        tick;
        check("clr2_pc_reset_drop", pc_reset, 0);
        check("clr2_req", imem_req, 1);

        run_instr("a0005", 16'h0005, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick;
        run_instr("a0010", 16'h0010, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0); tick;
        run_instr("a7fff", 16'h7FFF, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0); tick;
        run_instr("jeq_take", 16'hE302, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0); tick;
        run_instr("jeq_fall", 16'hE302, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick;
        run_instr("jmp", 16'hE307, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0); tick;
        run_instr("a_bits111", 16'h0007, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick;
        run_instr("jgt_take", 16'hE301, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0); tick;
        run_instr("jlt_take", 16'hE304, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0); tick;
        run_instr("jlt_fall", 16'hE304, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0); tick;

        start = 1'b1;
        tick;
        start = 1'b0;
        check("start_ignored_fetch", state_dbg, S_FETCH);

        run_instr("waits", 16'hE302, 3, 2, 1'b1, 1'b0, 1'b1, 1'b0); tick;

        run_instr("halt_wait", 16'h0005, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick;
        check("halt_state", state_dbg, S_HALT);
        check("halt_outs", outs(), 7'd0);
        check("halt_ir_hold", ir, 16'h0005);
        imem_ack = 1'b1; exec_done = 1'b1;
        tick;
        imem_ack = 1'b0; exec_done = 1'b0;
        check("halt_ignores_ack_done", state_dbg, S_HALT);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("resume_state", state_dbg, S_FETCH);
        check("resume_no_pc_reset", pc_reset, 0);
        run_instr("after_resume", 16'h0020, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        check("halt_pend_cleared", state_dbg, S_FETCH);

        reset = 1'b0;
        tick;
        reset = 1'b1; start = 1'b1; halt_req = 1'b1;
        tick;
        start = 1'b0; halt_req = 1'b0;
        check("start_halt_clr", state_dbg, S_CLR);
        tick;
        run_instr("start_halt", 16'h0011, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        check("start_halt_taken", state_dbg, S_HALT);

        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (15) tick;
        check("tmo_cycle16_fetch", state_dbg, S_FETCH);
        check("tmo_cycle16_err", err, 0);
        tick;
`ifdef PC_SEQ_TIMEOUT_EN
        check("tmo_halt", state_dbg, S_HALT);
        check("tmo_err", err, 1);
        check("tmo_busy", busy, 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("tmo_retry_state", state_dbg, S_FETCH);
        check("tmo_err_sticky", err, 1);
`else
        check("no_tmo_state", state_dbg, S_FETCH);
        check("no_tmo_err", err, 0);
        repeat (10) tick;
        check("no_tmo_state_late", state_dbg, S_FETCH);
        check("no_tmo_err_late", err, 0);
`endif
        reset = 1'b0;
        #1;
        check("final_reset_outs", outs(), 7'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/execute sequencer that drives the 16-bit program counter's `load`/`inc`/`reset` controls in the Hack-style CPU. It fetches an instruction over a req/ack handshake, starts the datapath, waits for ALU completion, and then either increments the PC or loads it from A. The jump decision comes from the instruction's jump bits and the ALU `zr`/`ng` flags. It sits between instruction memory, the ALU/datapath and the program counter.

## Interface
Parameters:
- `TIMEOUT`, 16: fetch watchdog limit in cycles. Used only when `PC_SEQ_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  leave IDLE (clear PC) or resume from HALT.
- `halt_req`  in  1  request halt after the current instruction. Sticky until taken.
- `imem_req`  out  1  instruction fetch request.
- `imem_ack`  in  1  fetch complete; `instr` valid this cycle.
- `instr`  in  16  instruction word from memory.
- `exec_start`  out  1  one-cycle pulse: datapath executes `ir`.
- `exec_done`  in  1  datapath finished; `zr`/`ng` valid this cycle.
- `zr`, `ng`  in  1 each  ALU zero / negative flags.
- `ir`  out  16  latched instruction register.
- `pc_load`, `pc_inc`, `pc_reset`  out  1 each  program counter controls. At most one is high in any cycle.
- `busy`  out  1  high in every state except IDLE and HALT.
- `err`  out  1  fetch timeout flag (tied 0 without the macro).

## Operation
- States (3-bit): IDLE=0, CLR=1, FETCH=2, EXEC=3, WAIT=4, UPDATE=5, HALT=6.
- Outputs are Moore-decoded from the state (plus the `take` register).
- State behaviour and transitions:
  - IDLE: all outputs 0. `start`=1 → CLR.
  - CLR: `pc_reset`=1 for one cycle → FETCH.
  - FETCH: `imem_req`=1. Stay until `imem_ack`=1. On ack, `ir` <= `instr` → EXEC.
  - EXEC: `exec_start`=1 for one cycle → WAIT.
  - WAIT: stay until `exec_done`=1. On done, compute `take` into a register → UPDATE.
  - UPDATE: `pc_load`=`take`, `pc_inc`=!`take` for one cycle. Then → HALT if halt is pending, else → FETCH.
  - HALT: all outputs 0, `ir` holds. `start`=1 → FETCH (resume, no PC clear).
- Jump rule:
  - A-instruction (`ir[15]`=0): `take`=0.
  - C-instruction: `take` = (`ir[2]`&`ng`) | (`ir[1]`&`zr`) | (`ir[0]`&!`ng`&!`zr`).
  - Jump bits 111 means an unconditional jump.
- The jump target comes from the datapath A register; this block never drives PC data.
- `halt_req`:
  - Latched into `halt_pend` in any state except IDLE.
  - Cleared on entry to HALT.
  - An instruction in flight always completes its UPDATE.
- Ignored inputs:
  - `start` outside IDLE/HALT.
  - `imem_ack` outside FETCH.
  - `exec_done` outside WAIT.
- `start` and `halt_req` together in IDLE: the start wins; halt is taken after the first instruction's UPDATE.
- Reset (`reset`=0), at any time including mid-fetch:
  - state=IDLE; `ir`=0; `take`=0; `halt_pend`=0; `err`=0.
  - All outputs 0 immediately, without waiting for a clock edge.

## Timing
- Reset values: `imem_req`, `exec_start`, `pc_load`, `pc_inc`, `pc_reset`, `busy`, `err` = 0; `ir`=16'h0000.
- `start` sampled in IDLE → `pc_reset` high the next cycle. The PC reads 0 one edge later.
- Minimum instruction period is 4 cycles (FETCH, EXEC, WAIT, UPDATE), reached when ack and done arrive on the first cycle of their states.
- `ir` is valid from the first EXEC cycle until the next fetch's ack.
- The PC value changes on the edge that ends UPDATE.
- `imem_req` stays high continuously through FETCH. It drops the cycle after ack.

## Configuration
- `PC_SEQ_TIMEOUT_EN` defined:
  - A counter runs in FETCH and clears on entry to FETCH.
  - If `TIMEOUT` cycles elapse without `imem_ack`: `err` <= 1 (sticky until reset), state → HALT.
  - Resuming from HALT with `start` retries the fetch. `err` stays 1.
- `PC_SEQ_TIMEOUT_EN` undefined: no counter; FETCH waits indefinitely; `err` tied 0.

## Test plan
- Reset/clear: `reset`=0 mid-FETCH → all outputs 0 immediately. Then `start` → `pc_reset` high exactly one cycle, then `imem_req`=1.
- Sequential: three A-instructions (16'h0005 etc.), each with immediate ack/done → `pc_inc` pulses every 4 cycles; `pc_load` never high.
- Conditional jump:
  - `instr`=16'hE302 (JEQ) with `zr`=1 at `exec_done` → `pc_load`=1, `pc_inc`=0.
  - Same instruction with `zr`=0 → `pc_inc`=1.
  - 16'hE307 (JMP) with `zr`=0, `ng`=0 → `pc_load`=1.
- Wait states: ack delayed 3 cycles, done delayed 2 → `imem_req` high 4 cycles, exactly one `exec_start`, exactly one PC control pulse.
- Halt/resume:
  - `halt_req` pulsed during WAIT → UPDATE completes, then HALT with `busy`=0.
  - `start` → FETCH with no `pc_reset`.
- Timeout (macro on, `TIMEOUT`=16): no ack → `err`=1 and HALT on cycle 16. Without the macro, FETCH persists and `err`=0.
